// File: rtl/rgb_maxmin_pipe_if.sv
// Pixel-stream bundle for rgb_maxmin_pipe: RGB plus tag in, max/min/delta out,
// with valid/ready handshakes on both sides.
interface rgb_maxmin_pipe_if #(
  parameter int WIDTH  = 8,
  parameter int USER_W = 2
);
  logic [WIDTH-1:0]  r_in;
  logic [WIDTH-1:0]  g_in;
  logic [WIDTH-1:0]  b_in;
  logic [USER_W-1:0] user_in;
  logic              valid_in;
  logic              ready_out;

  logic [WIDTH-1:0]  v;
  logic [WIDTH-1:0]  min;
  logic [WIDTH-1:0]  delta;
  logic [1:0]        max_sel;
  logic              gray;
  logic [USER_W-1:0] user_out;
  logic              valid_out;
  logic              ready_in;

  modport master (
    output r_in, g_in, b_in, user_in, valid_in, ready_in,
    input  ready_out, v, min, delta, max_sel, gray, user_out, valid_out
  );

  modport slave (
    input  r_in, g_in, b_in, user_in, valid_in, ready_in,
    output ready_out, v, min, delta, max_sel, gray, user_out, valid_out
  );
endinterface

// File: rtl/rgb_maxmin_pipe.sv
// Two-stage max/min extractor for the RGB-to-HSV front end: stage 1 orders R/G,
// stage 2 folds in B and produces V, MIN, DELTA, max-channel index and gray flag.
module rgb_maxmin_pipe #(
  parameter int WIDTH  = 8,
  parameter int USER_W = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  rgb_maxmin_pipe_if.slave  bus
);

  logic              s1_valid;
  logic [WIDTH-1:0]  s1_max;
  logic [WIDTH-1:0]  s1_min;
  logic [WIDTH-1:0]  s1_b;
  logic              s1_sel;
  logic [USER_W-1:0] s1_user;
  logic              s2_valid;

  logic              load1;
  logic              load2;
  logic              rg_ge;
  logic              hi_ge_b;
  logic              lo_le_b;
  logic [WIDTH-1:0]  v_nxt;
  logic [WIDTH-1:0]  min_nxt;

  // A stage may load whenever it is empty or its contents move on this cycle,
  // so bubbles collapse even while the output is stalled.
  assign load2         = !s2_valid || bus.ready_in;
  assign load1         = !s1_valid || load2;
  assign bus.ready_out = load1;
  assign bus.valid_out = s2_valid;

  assign rg_ge   = bus.r_in >= bus.g_in;
  assign hi_ge_b = s1_max >= s1_b;
  assign lo_le_b = s1_min <= s1_b;
  assign v_nxt   = hi_ge_b ? s1_max : s1_b;
  assign min_nxt = lo_le_b ? s1_min : s1_b;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_max   <= '0;
      s1_min   <= '0;
      s1_b     <= '0;
      s1_sel   <= 1'b0;
      s1_user  <= '0;
    end else if (load1) begin
      s1_valid <= bus.valid_in;
      if (bus.valid_in) begin
        s1_max  <= rg_ge ? bus.r_in : bus.g_in;
        s1_min  <= rg_ge ? bus.g_in : bus.r_in;
        s1_sel  <= !rg_ge;
        s1_b    <= bus.b_in;
        s1_user <= bus.user_in;
      end
    end
  end

  // The >= compares give ties to the earlier channel, so R beats G beats B.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid     <= 1'b0;
      bus.v        <= '0;
      bus.min      <= '0;
      bus.delta    <= '0;
      bus.max_sel  <= 2'd0;
      bus.gray     <= 1'b1;
      bus.user_out <= '0;
    end else if (load2) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        bus.v        <= v_nxt;
        bus.min      <= min_nxt;
        bus.delta    <= v_nxt - min_nxt;
        bus.max_sel  <= hi_ge_b ? {1'b0, s1_sel} : 2'd2;
        bus.gray     <= (v_nxt == min_nxt);
        bus.user_out <= s1_user;
      end
    end
  end

endmodule

// File: tb/tb_rgb_maxmin_pipe.sv
// Self-checking bench for rgb_maxmin_pipe: a max/min reference model with an
// in-order expectation queue, plus directed vectors with literal results.
module tb_rgb_maxmin_pipe;

  logic clk = 1'b0;
  logic rst_n;

  always #5 clk = ~clk;

  rgb_maxmin_pipe_if #(.WIDTH(8),  .USER_W(2)) bus   ();
  rgb_maxmin_pipe_if #(.WIDTH(10), .USER_W(2)) bus10 ();

  rgb_maxmin_pipe #(.WIDTH(8), .USER_W(2)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  rgb_maxmin_pipe #(.WIDTH(10), .USER_W(2)) dut10 (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus10)
  );

  typedef struct {
    int v;
    int mn;
    int delta;
    int sel;
    int gray;
    int user;
  } exp_t;

  exp_t exp_q[$];
  int total = 0;
  int bad = 0;
  int cyc = 0;
  int out_count = 0;
  int tp_first_out = -1;
  int tp_last_out = -1;

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Reference: V/MIN are plain max/min of three; MAX_SEL is the first channel holding V.
  function automatic exp_t model(input int r, input int g, input int b, input int user);
    int   ch[3];
    exp_t e;
    ch[0] = r;
    ch[1] = g;
    ch[2] = b;
    e.v  = ch[0];
    e.mn = ch[0];
    for (int i = 1; i < 3; i++) begin
      if (ch[i] > e.v)  e.v  = ch[i];
      if (ch[i] < e.mn) e.mn = ch[i];
    end
    e.sel = 3;
    for (int i = 2; i >= 0; i--)
      if (ch[i] == e.v) e.sel = i;
    e.delta = e.v - e.mn;
    e.gray  = (e.delta == 0) ? 1 : 0;
    e.user  = user;
    return e;
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Outputs are checked against the queue head every valid cycle, including stalled ones.
  always @(negedge clk) begin
    if (!rst_n) begin
      exp_q.delete();
    end else begin
      if (bus.valid_out) begin
        check_output("have_expected", 32'(exp_q.size() > 0), 32'd1);
        if (exp_q.size() > 0) begin
          check_output("model_v",       32'(bus.v),        exp_q[0].v);
          check_output("model_min",     32'(bus.min),      exp_q[0].mn);
          check_output("model_delta",   32'(bus.delta),    exp_q[0].delta);
          check_output("model_max_sel", 32'(bus.max_sel),  exp_q[0].sel);
          check_output("model_gray",    32'(bus.gray),     exp_q[0].gray);
          check_output("model_user",    32'(bus.user_out), exp_q[0].user);
          if (bus.ready_in) begin
            void'(exp_q.pop_front());
            out_count++;
            if (tp_first_out < 0) tp_first_out = cyc;
            tp_last_out = cyc;
          end
        end
      end
      if (bus.valid_in && bus.ready_out)
        exp_q.push_back(model(int'(bus.r_in), int'(bus.g_in), int'(bus.b_in), int'(bus.user_in)));
    end
  end

  task automatic apply_stimulus(input int r, input int g, input int b, input int user);
    int waits = 0;
    bus.r_in     = 8'(r);
    bus.g_in     = 8'(g);
    bus.b_in     = 8'(b);
    bus.user_in  = 2'(user);
    bus.valid_in = 1'b1;
    @(negedge clk);
    while (!bus.ready_out && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check_output("accepted", 32'(bus.ready_out), 32'd1);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic wait_valid(input string name);
    int n = 0;
    @(negedge clk);
    while (!bus.valid_out && n < 8) begin
      @(negedge clk);
      n++;
    end
    check_output(name, 32'(bus.valid_out), 32'd1);
  endtask

  task automatic expect_lit(input int r, input int g, input int b, input int ev, input int emin,
                            input int edelta, input int esel, input int egray);
    @(posedge clk);
    #1;
    apply_stimulus(r, g, b, r & 3);
    wait_valid("lit_valid");
    check_output("lit_v",       32'(bus.v),       ev);
    check_output("lit_min",     32'(bus.min),     emin);
    check_output("lit_delta",   32'(bus.delta),   edelta);
    check_output("lit_max_sel", 32'(bus.max_sel), esel);
    check_output("lit_gray",    32'(bus.gray),    egray);
  endtask

  task automatic drain();
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    repeat (4) @(negedge clk);
    check_output("drained", 32'(exp_q.size()), 32'd0);
  endtask

  task automatic check_reset_values(input string tag);
    check_output({tag, "_valid_out"}, 32'(bus.valid_out), 32'd0);
    check_output({tag, "_v"},         32'(bus.v),         32'd0);
    check_output({tag, "_min"},       32'(bus.min),       32'd0);
    check_output({tag, "_delta"},     32'(bus.delta),     32'd0);
    check_output({tag, "_max_sel"},   32'(bus.max_sel),   32'd0);
    check_output({tag, "_gray"},      32'(bus.gray),      32'd1);
    check_output({tag, "_user_out"},  32'(bus.user_out),  32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish, bad=%0d", bad);
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int accepts;
    int idx;
    int stale;
    int base;
    int tp_first_acc;
    int pa_r[5];
    int pa_g[5];
    int pa_b[5];

    bus.r_in      = '0;
    bus.g_in      = '0;
    bus.b_in      = '0;
    bus.user_in   = '0;
    bus.valid_in  = 1'b0;
    bus.ready_in  = 1'b1;
    bus10.r_in    = '0;
    bus10.g_in    = '0;
    bus10.b_in    = '0;
    bus10.user_in = '0;
    bus10.valid_in = 1'b0;
    bus10.ready_in = 1'b1;

    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    #2;
    check_reset_values("por");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    $display("[TB] directed orderings and ties");
    expect_lit(200, 50, 10,  200, 10, 190, 0, 0);
    expect_lit(10, 200, 50,  200, 10, 190, 1, 0);
    expect_lit(50, 10, 200,  200, 10, 190, 2, 0);
    expect_lit(7, 7, 7,      7, 7, 0, 0, 1);
    expect_lit(90, 90, 30,   90, 30, 60, 0, 0);
    expect_lit(30, 90, 90,   90, 30, 60, 1, 0);
    expect_lit(255, 0, 255,  255, 0, 255, 0, 0);
    expect_lit(0, 0, 0,      0, 0, 0, 0, 1);
    drain();

    $display("[TB] throughput");
    tp_first_out = -1;
    tp_first_acc = -1;
    base = out_count;
    @(posedge clk);
    #1;
    for (int i = 0; i < 100; i++) begin
      if (i % 3 == 0) begin
        bus.r_in = 8'($urandom_range(0, 3));
        bus.g_in = 8'($urandom_range(0, 3));
        bus.b_in = 8'($urandom_range(0, 3));
      end else begin
        bus.r_in = 8'($urandom_range(0, 255));
        bus.g_in = 8'($urandom_range(0, 255));
        bus.b_in = 8'($urandom_range(0, 255));
      end
      bus.user_in  = 2'(i);
      bus.valid_in = 1'b1;
      @(negedge clk);
      if (i == 0) tp_first_acc = cyc;
      @(posedge clk);
      #1;
    end
    bus.valid_in = 1'b0;
    repeat (5) @(negedge clk);
    check_output("tp_count",      32'(out_count - base),            32'd100);
    check_output("tp_latency",    32'(tp_first_out - tp_first_acc), 32'd2);
    check_output("tp_contiguous", 32'(tp_last_out - tp_first_out),  32'd99);
    drain();

    $display("[TB] backpressure");
    pa_r[0] = 200; pa_g[0] = 50; pa_b[0] = 10;
    pa_r[1] = 30;  pa_g[1] = 90; pa_b[1] = 90;
    for (int i = 2; i < 5; i++) begin
      pa_r[i] = 11 * i; pa_g[i] = 5; pa_b[i] = 3;
    end
    @(posedge clk);
    #1;
    bus.ready_in = 1'b0;
    accepts = 0;
    idx = 0;
    for (int k = 0; k < 5; k++) begin
      bus.r_in     = 8'(pa_r[idx]);
      bus.g_in     = 8'(pa_g[idx]);
      bus.b_in     = 8'(pa_b[idx]);
      bus.user_in  = 2'(idx + 1);
      bus.valid_in = 1'b1;
      @(negedge clk);
      if (bus.ready_out) begin
        accepts++;
        if (idx < 4) idx++;
      end
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check_output("bp_accepts",   32'(accepts),       32'd2);
    check_output("bp_ready_out", 32'(bus.ready_out), 32'd0);
    check_output("bp_held_v",    32'(bus.v),         32'd200);
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    bus.ready_in = 1'b1;
    @(negedge clk);
    check_output("bp_rel0_v",   32'(bus.v),       32'd200);
    check_output("bp_rel0_sel", 32'(bus.max_sel), 32'd0);
    @(negedge clk);
    check_output("bp_rel1_v",   32'(bus.v),       32'd90);
    check_output("bp_rel1_sel", 32'(bus.max_sel), 32'd1);
    drain();

    $display("[TB] bubble collapse");
    @(posedge clk);
    #1;
    apply_stimulus(40, 60, 20, 1);
    bus.ready_in = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    bus.r_in     = 8'd5;
    bus.g_in     = 8'd6;
    bus.b_in     = 8'd7;
    bus.user_in  = 2'd2;
    bus.valid_in = 1'b1;
    @(negedge clk);
    check_output("bubble_ready_out", 32'(bus.ready_out), 32'd1);
    check_output("bubble_held_v",    32'(bus.v),         32'd60);
    @(posedge clk);
    #1;
    bus.r_in = 8'd9;
    @(negedge clk);
    check_output("bubble_full_ready", 32'(bus.ready_out), 32'd0);
    drain();

    $display("[TB] reset with pixels in flight");
    @(posedge clk);
    #1;
    bus.r_in = 8'd100; bus.g_in = 8'd20; bus.b_in = 8'd3; bus.user_in = 2'd3;
    bus.valid_in = 1'b1;
    @(posedge clk);
    #1;
    bus.r_in = 8'd1; bus.g_in = 8'd2; bus.b_in = 8'd250; bus.user_in = 2'd1;
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    check_reset_values("midrst");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    stale = 0;
    repeat (6) begin
      @(negedge clk);
      if (bus.valid_out) stale++;
    end
    check_output("no_stale_after_reset", 32'(stale), 32'd0);

    $display("[TB] WIDTH=10 extreme");
    @(posedge clk);
    #1;
    bus10.r_in     = 10'd1023;
    bus10.g_in     = 10'd0;
    bus10.b_in     = 10'd512;
    bus10.valid_in = 1'b1;
    @(negedge clk);
    check_output("w10_ready_out", 32'(bus10.ready_out), 32'd1);
    @(posedge clk);
    #1;
    bus10.valid_in = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check_output("w10_valid",   32'(bus10.valid_out), 32'd1);
    check_output("w10_v",       32'(bus10.v),         32'd1023);
    check_output("w10_min",     32'(bus10.min),       32'd0);
    check_output("w10_delta",   32'(bus10.delta),     32'd1023);
    check_output("w10_max_sel", 32'(bus10.max_sel),   32'd0);
    check_output("w10_gray",    32'(bus10.gray),      32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
